// File: rtl/rbzero_compositor.sv
// Registered pixel compositor for raybox-zero: per-line wall latch, per-frame overlay enables,
// prioritised overlay layers and a PIPE-deep output pipeline with matching sync delay.
module rbzero_compositor #(
  parameter int               LAYERS = 2,
  parameter int               BPC    = 2,
  parameter int               H_VIEW = 640,
  parameter int               PIPE   = 2,
  parameter logic [3*BPC-1:0] BG_A   = 6'b10_10_10,
  parameter logic [3*BPC-1:0] BG_B   = 6'b01_01_01,
  parameter logic [3*BPC-1:0] WALL_A = 6'b11_00_00,
  parameter logic [3*BPC-1:0] WALL_B = 6'b10_00_00
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [9:0]                 hpos,
  input  logic                       visible,
  input  logic                       hsync,
  input  logic                       vsync,
  input  logic                       hmax,
  input  logic                       vmax,
  input  logic                       wall_side,
  input  logic [10:0]                wall_size,
  input  logic [LAYERS-1:0]          layer_en_req,
  input  logic [LAYERS-1:0]          layer_hit,
  input  logic [LAYERS*3*BPC-1:0]    layer_rgb,
  output logic [3*BPC-1:0]           rgb,
  output logic                       hsync_n,
  output logic                       vsync_n
);

  localparam int          P    = 3 * BPC;
  localparam logic [10:0] HALF = 11'(H_VIEW / 2);

  logic [10:0]       r_disp_size;
  logic              r_disp_side;
  logic [LAYERS-1:0] r_en_q;

  // Wall result is taken at end of line; overlay enables only at end of frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp_size <= '0;
      r_disp_side <= 1'b0;
      r_en_q      <= '1;
    end else if (hmax) begin
      r_disp_size <= wall_size;
      r_disp_side <= wall_side;
      if (vmax) r_en_q <= layer_en_req;
    end
  end

  logic [10:0] w_s;
  logic [10:0] w_lo;
  logic [10:0] w_hi;
  logic [10:0] w_hpos;
  logic        w_wall_hit;

  assign w_s        = (r_disp_size > HALF) ? HALF : r_disp_size;
  assign w_lo       = HALF - w_s;
  assign w_hi       = HALF + w_s;
  assign w_hpos     = {1'b0, hpos};
  assign w_wall_hit = (w_hpos >= w_lo) && (w_hpos < w_hi);

  logic                  r_s1_wall;
  logic                  r_s1_side;
  logic                  r_s1_bg;
  logic                  r_s1_vis;
  logic                  r_s1_hs;
  logic                  r_s1_vs;
  logic [LAYERS-1:0]     r_s1_hit;
  logic [LAYERS*P-1:0]   r_s1_lrgb;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_wall <= 1'b0;
      r_s1_side <= 1'b0;
      r_s1_bg   <= 1'b0;
      r_s1_vis  <= 1'b0;
      r_s1_hs   <= 1'b0;
      r_s1_vs   <= 1'b0;
      r_s1_hit  <= '0;
      r_s1_lrgb <= '0;
    end else begin
      r_s1_wall <= w_wall_hit;
      r_s1_side <= r_disp_side;
      r_s1_bg   <= (w_hpos < HALF);
      r_s1_vis  <= visible;
      r_s1_hs   <= hsync;
      r_s1_vs   <= vsync;
      r_s1_hit  <= layer_hit & r_en_q;
      r_s1_lrgb <= layer_rgb;
    end
  end

  logic [P-1:0] w_pix;

  // Walk from lowest priority upward so layer 0 is applied last and wins.
  always_comb begin
    w_pix = r_s1_bg ? BG_A : BG_B;
    if (r_s1_wall) w_pix = r_s1_side ? WALL_A : WALL_B;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (r_s1_hit[k]) w_pix = r_s1_lrgb[k*P +: P];
    end
    if (!r_s1_vis) w_pix = '0;
  end

  // Index 0 is stage 2; indices 1..PIPE-2 are pure delay stages.
  logic [P-1:0]  r_rgb_d [PIPE-1];
  logic [PIPE-2:0] r_hs_d;
  logic [PIPE-2:0] r_vs_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE - 1; i++) r_rgb_d[i] <= '0;
      r_hs_d <= '0;
      r_vs_d <= '0;
    end else begin
      r_rgb_d[0] <= w_pix;
      r_hs_d[0]  <= r_s1_hs;
      r_vs_d[0]  <= r_s1_vs;
      for (int i = 1; i < PIPE - 1; i++) begin
        r_rgb_d[i] <= r_rgb_d[i-1];
        r_hs_d[i]  <= r_hs_d[i-1];
        r_vs_d[i]  <= r_vs_d[i-1];
      end
    end
  end

  assign rgb     = r_rgb_d[PIPE-2];
  assign hsync_n = ~r_hs_d[PIPE-2];
  assign vsync_n = ~r_vs_d[PIPE-2];

endmodule
